bin_to_bcd_conv: RTL and testbench

Sequential binary-to-BCD converter. Accepts a 32-bit unsigned binary word with a one-cycle strobe and returns its 10-digit packed BCD equivalent with a one-cycle output strobe. It uses a shift-and-double algorithm: MSB first, one binary bit per clock, BCD accumulator doubled plus incoming bit. It sits between binary counters/registers and decimal display or formatting logic.

---
 rtl/bin_to_bcd_conv_pkg.sv | 18 +
 rtl/bin_to_bcd_conv_bcd_shl_1.sv | 44 ++++
 rtl/bin_to_bcd_conv.sv | 93 +++++++++
 tb/tb_bin_to_bcd_conv.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_conv_pkg.sv
// Shared constants, FSM state type and digit sizing for the binary-to-BCD converter.
// No logic: it holds only declarations.
package bin_to_bcd_conv_pkg;

    localparam int BCD_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Number of decimal digits in 2^bin_w - 1, which is floor(bin_w*log10(2)) + 1.
    // A power of two is never a power of ten, so the floor is exact.
    function automatic int calc_digits(input int bin_w);
        return (bin_w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_conv_bcd_shl_1.sv
// Clocked BCD register that doubles and adds one incoming bit per enabled cycle, with a sticky overflow flag.
// Latency: one cycle. No backpressure. When CLR and EN are high together, the register loads ADD1, which is 0*2 + ADD1.
module bcd_shl_1
    import bin_to_bcd_conv_pkg::*;
#(
    parameter int DIGITS = 10
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CLR,
    input  logic                      EN,
    input  logic                      ADD1,
    output logic [BCD_W*DIGITS-1:0]   DAT,
    output logic                      OVERFLOW
);

    logic [DIGITS:0]           carry;
    logic [BCD_W*DIGITS-1:0]   dbl;

    assign carry[0] = ADD1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [4:0] t;
        assign t            = {DAT[g*BCD_W +: BCD_W], 1'b0} + {4'd0, carry[g]};
        assign carry[g+1]   = (t >= 5'd10);
        assign dbl[g*BCD_W +: BCD_W] = carry[g+1] ? 4'(t - 5'd10) : t[3:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DAT      <= '0;
            OVERFLOW <= 1'b0;
        end else if (CLR) begin
            DAT      <= EN ? (BCD_W*DIGITS)'(ADD1) : '0;
            OVERFLOW <= 1'b0;
        end else if (EN) begin
            DAT <= dbl;
            if (carry[DIGITS]) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bin_to_bcd_conv.sv
// Converts binary to BCD sequentially using shift-and-double, consuming one bit per clock, MSB first.
// O_STB rises BIN_W cycles after the edge that accepts I_STB. I_STB is ignored while a conversion is in progress.
module bin_to_bcd_conv
    import bin_to_bcd_conv_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = calc_digits(BIN_W)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [BIN_W-1:0]          I_DAT,
    input  logic                      I_STB,
    output logic [BCD_W*DIGITS-1:0]   O_DAT,
    output logic                      O_STB
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic [BIN_W-1:0]          shreg;
    logic                      acc_clr, acc_en, acc_add1, done;
    logic [BCD_W*DIGITS-1:0]   acc_dat;
    logic                      acc_ovf;

    // The accept edge already folds the MSB into the cleared accumulator.
    // The remaining BIN_W-1 bits then fill the following edges.
    // The final BUSY edge only moves the finished result to O_DAT, so the total latency stays BIN_W.
    bcd_shl_1 #(.DIGITS(DIGITS)) u_acc (
        .CLK      (CLK),
        .RST      (RST),
        .CLR      (acc_clr),
        .EN       (acc_en),
        .ADD1     (acc_add1),
        .DAT      (acc_dat),
        .OVERFLOW (acc_ovf)
    );

    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        acc_add1  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (I_STB) begin
                    acc_clr   = 1'b1;
                    acc_en    = 1'b1;
                    acc_add1  = I_DAT[BIN_W-1];
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    acc_en   = 1'b1;
                    acc_add1 = shreg[BIN_W-1];
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            O_DAT <= '0;
            O_STB <= 1'b0;
        end else begin
            state <= state_nxt;
            O_STB <= done;
            if (done) begin
                O_DAT <= acc_dat;
            end
            if (state == IDLE && I_STB) begin
                shreg <= I_DAT << 1;
                cnt   <= CNT_W'(BIN_W - 1);
            end else if (state == BUSY && cnt != '0) begin
                shreg <= shreg << 1;
                cnt   <= cnt - CNT_W'(1);
            end
        end
    end

    // With DIGITS sized from BIN_W, the accumulator can never carry out of its top digit.
    a_no_overflow: assert property (@(posedge CLK) disable iff (RST) !acc_ovf);

endmodule

// File: tb/tb_bin_to_bcd_conv.sv
// Testbench for bin_to_bcd_conv and bcd_shl_1 that checks results against a queue of expected values.
// Expected BCD values come from a divide-by-ten model; the expected strobe time is the start cycle plus 33.
module tb_bin_to_bcd_conv;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] I_DAT = '0;
    logic        I_STB = 1'b0;
    logic [39:0] O_DAT;
    logic        O_STB;

    logic        s_clr = 1'b0, s_en = 1'b0, s_add1 = 1'b0;
    logic [39:0] s_dat;
    logic        s_ovf;

    int          cyc = 0;
    int          vectors = 0;
    int          fails = 0;
    logic [39:0] exp_dat[$];
    int          exp_cyc[$];

    bin_to_bcd_conv #(.BIN_W(32), .DIGITS(10)) dut (
        .CLK(CLK), .RST(RST), .I_DAT(I_DAT), .I_STB(I_STB), .O_DAT(O_DAT), .O_STB(O_STB)
    );

    bcd_shl_1 #(.DIGITS(10)) u_shl (
        .CLK(CLK), .RST(RST), .CLR(s_clr), .EN(s_en), .ADD1(s_add1), .DAT(s_dat), .OVERFLOW(s_ovf)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [39:0] to_bcd(input logic [31:0] v);
        logic [39:0] r;
        logic [31:0] x;
        r = '0;
        x = v;
        for (int i = 0; i < 10; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Advances one clock and drains the scoreboard on every strobe seen at the falling edge.
    task automatic tick();
        logic [39:0] e;
        int          c;
        @(negedge CLK);
        if (O_STB) begin
            if (exp_dat.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL unexpected_stb: got O_STB=1 O_DAT=%h at cycle %0d, want no strobe", O_DAT, cyc);
            end else begin
                e = exp_dat.pop_front();
                c = exp_cyc.pop_front();
                vectors += 2;
                if (O_DAT !== e) begin
                    fails++;
                    $display("FAIL o_dat: got %h want %h", O_DAT, e);
                end
                if (cyc !== c) begin
                    fails++;
                    $display("FAIL latency: got strobe at cycle %0d want %0d", cyc, c);
                end
            end
        end
    endtask

    task automatic start(input logic [31:0] v, input bit push);
        I_DAT = v;
        I_STB = 1'b1;
        if (push) begin
            exp_dat.push_back(to_bcd(v));
            exp_cyc.push_back(cyc + 33);
        end
        tick();
        I_STB = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && exp_dat.size() != 0; i++) tick();
        if (exp_dat.size() != 0) begin
            vectors++;
            fails++;
            $display("FAIL timeout: got %0d pending results after %0d cycles, want 0", exp_dat.size(), limit);
            exp_dat.delete();
            exp_cyc.delete();
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        vectors += 4;
        if (O_DAT !== 40'h0) begin fails++; $display("FAIL rst_o_dat: got %h want 0", O_DAT); end
        if (O_STB !== 1'b0)  begin fails++; $display("FAIL rst_o_stb: got %b want 0", O_STB); end
        if (s_dat !== 40'h0) begin fails++; $display("FAIL rst_shl_dat: got %h want 0", s_dat); end
        if (s_ovf !== 1'b0)  begin fails++; $display("FAIL rst_shl_ovf: got %b want 0", s_ovf); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] vals[5] = '{32'd8, 32'd0, 32'd99, 32'd1234567890, 32'hFFFF_FFFF};
        foreach (vals[i]) begin
            start(vals[i], 1'b1);
            wait_done(40);
        end
        for (int i = 0; i < 3; i++) begin
            start($urandom, 1'b1);
            wait_done(40);
        end
    endtask

    task automatic test_back_to_back();
        start(32'd77, 1'b1);
        repeat (9) tick();
        start(32'd5, 1'b0);
        wait_done(40);
        repeat (5) tick();
        start(32'd5, 1'b1);
        wait_done(40);
        start(32'd31415, 1'b1);
        wait_done(40);
        start(32'd11, 1'b1);
        repeat (31) tick();
        start(32'd12, 1'b0);
        repeat (40) tick();
    endtask

    task automatic test_reset_mid();
        start(32'd555555, 1'b1);
        repeat (14) tick();
        RST = 1'b1;
        #1;
        vectors += 2;
        if (O_DAT !== 40'h0) begin fails++; $display("FAIL midrst_o_dat: got %h want 0", O_DAT); end
        if (O_STB !== 1'b0)  begin fails++; $display("FAIL midrst_o_stb: got %b want 0", O_STB); end
        exp_dat.delete();
        exp_cyc.delete();
        tick();
        RST = 1'b0;
        repeat (40) tick();
        start(32'd2024, 1'b1);
        wait_done(40);
    endtask

    task automatic test_shl_count();
        logic [39:0] exp_t[5] = '{40'h1, 40'h2, 40'h4, 40'h8, 40'h16};
        s_clr = 1'b1;
        s_en  = 1'b0;
        tick();
        s_clr  = 1'b0;
        s_en   = 1'b1;
        s_add1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (s_dat !== exp_t[i]) begin fails++; $display("FAIL shl_count[%0d]: got %h want %h", i, s_dat, exp_t[i]); end
            s_add1 = 1'b0;
        end
        s_en = 1'b0;
    endtask

    task automatic test_shl_overflow();
        logic [32:0] v = 33'd5000000000;
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        s_en  = 1'b1;
        for (int i = 32; i >= 0; i--) begin
            s_add1 = v[i];
            tick();
        end
        s_en = 1'b0;
        vectors += 2;
        if (s_dat !== 40'h5000000000) begin fails++; $display("FAIL shl_preload: got %h want 5000000000", s_dat); end
        if (s_ovf !== 1'b0) begin fails++; $display("FAIL shl_preload_ovf: got %b want 0", s_ovf); end
        s_en   = 1'b1;
        s_add1 = 1'b0;
        tick();
        vectors += 2;
        if (s_ovf !== 1'b1) begin fails++; $display("FAIL shl_ovf_set: got %b want 1", s_ovf); end
        if (s_dat !== 40'h0) begin fails++; $display("FAIL shl_ovf_dat: got %h want 0", s_dat); end
        s_en = 1'b0;
        tick();
        vectors++;
        if (s_ovf !== 1'b1) begin fails++; $display("FAIL shl_ovf_hold: got %b want 1", s_ovf); end
        s_en = 1'b1;
        tick();
        vectors++;
        if (s_ovf !== 1'b1) begin fails++; $display("FAIL shl_ovf_sticky: got %b want 1", s_ovf); end
        s_en  = 1'b0;
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        vectors++;
        if (s_ovf !== 1'b0) begin fails++; $display("FAIL shl_ovf_clr: got %b want 0", s_ovf); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid();
        test_shl_count();
        test_shl_overflow();
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
